// File: rtl/as6501_rx_multi.sv
// as6501_rx_multi: multi-channel AS6501 TDC serial result receiver.
// Each channel deserialises an {idx, stop} word, tags it with the global
// counter value at frame start and parks it in a one-entry holding register.
// A round-robin arbiter merges the holding registers into an FWFT FIFO that
// drives an AXI-Stream master.
// Optional build macro AS6501_GATE_FILTER_EN: when defined, only words whose
// stop field lies in [gate_lo_i, gate_hi_i] are kept.
//
// Channel FSM states:
//   state | meaning
//   IDLE  | waiting for frame_i with enable_i high
//   SHIFT | shifting result bits in, bitcnt = bits already taken
module as6501_rx_multi #(
    parameter int NCH        = 4,
    parameter int IDX_W      = 8,
    parameter int STOP_W     = 16,
    parameter int GC_W       = 48,
    parameter int FIFO_DEPTH = 16,
    localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                          lclk_i,
    input  logic                          lrst_i,
    input  logic                          enable_i,
    input  logic                          gc_rst_i,
    input  logic [NCH-1:0]                frame_i,
    input  logic [NCH-1:0]                sdi_i,
    input  logic [STOP_W-1:0]             gate_lo_i,
    input  logic [STOP_W-1:0]             gate_hi_i,
    output logic [GC_W+CW+IDX_W+STOP_W-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [GC_W-1:0]               gc_o,
    output logic [15:0]                   drop_cnt_o,
    output logic [15:0]                   frame_err_cnt_o,
    output logic [LW-1:0]                 fifo_level_o
);
    localparam int RES_W = IDX_W + STOP_W;
    localparam int DW    = GC_W + CW + RES_W;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int BW    = $clog2(RES_W + 1);

    typedef enum logic {IDLE, SHIFT} ch_state_t;

    logic [GC_W-1:0]  gc;
    ch_state_t        st      [NCH];
    logic [BW-1:0]    bitcnt  [NCH];
    logic [RES_W-2:0] shreg   [NCH];
    logic [GC_W-1:0]  gc_lat  [NCH];
    logic [RES_W-1:0] word    [NCH];
    logic [DW-1:0]    hold_data [NCH];
    logic [NCH-1:0]   hold_valid;
    logic [NCH-1:0]   done, accept, abort, drop, grant_oh;
    logic [3:0]       drop_n, err_n;
    logic [CW-1:0]    rr_ptr, grant_ch, cand;
    logic             grant_vld;

    logic [DW-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    mem_cnt, level;
    logic [DW-1:0]    out_data;
    logic             out_valid, fifo_rd, fetch, fifo_full;

`ifndef AS6501_GATE_FILTER_EN
    wire unused_gate = ^{gate_lo_i, gate_hi_i};
`endif

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] n);
        logic [16:0] s;
        s = {1'b0, a} + {13'b0, n};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Word completion, re-frame abort, gate decision and drop detection per channel
    always_comb begin
        drop_n = '0;
        err_n  = '0;
        for (int c = 0; c < NCH; c++) begin
            word[c]  = {shreg[c], sdi_i[c]};
            done[c]  = (st[c] == SHIFT) && enable_i && !frame_i[c] && (bitcnt[c] == BW'(RES_W - 1));
            abort[c] = (st[c] == SHIFT) && enable_i && frame_i[c];
`ifdef AS6501_GATE_FILTER_EN
            accept[c] = done[c] && (word[c][STOP_W-1:0] >= gate_lo_i)
                                && (word[c][STOP_W-1:0] <= gate_hi_i);
`else
            accept[c] = done[c];
`endif
            drop[c] = accept[c] && hold_valid[c] && !grant_oh[c];
            drop_n  = drop_n + 4'(drop[c]);
            err_n   = err_n + 4'(abort[c]);
        end
    end

    // Global counter: clear wins over count
    always_ff @(posedge lclk_i or posedge lrst_i) begin
        if (lrst_i)        gc <= '0;
        else if (gc_rst_i) gc <= '0;
        else if (enable_i) gc <= gc + GC_W'(1);
    end

    // Per-channel deserialiser FSMs
    always_ff @(posedge lclk_i or posedge lrst_i) begin
        if (lrst_i) begin
            for (int c = 0; c < NCH; c++) begin
                st[c]     <= IDLE;
                bitcnt[c] <= '0;
                shreg[c]  <= '0;
                gc_lat[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                case (st[c])
                    IDLE: begin
                        if (enable_i && frame_i[c]) begin
                            st[c]     <= SHIFT;
                            shreg[c]  <= {{(RES_W-2){1'b0}}, sdi_i[c]};
                            gc_lat[c] <= gc;
                            bitcnt[c] <= BW'(1);
                        end
                    end
                    SHIFT: begin
                        if (!enable_i) begin
                            st[c] <= IDLE;
                        end else if (frame_i[c]) begin
                            shreg[c]  <= {{(RES_W-2){1'b0}}, sdi_i[c]};
                            gc_lat[c] <= gc;
                            bitcnt[c] <= BW'(1);
                        end else begin
                            shreg[c]  <= word[c][RES_W-2:0];
                            bitcnt[c] <= bitcnt[c] + BW'(1);
                            if (done[c]) st[c] <= IDLE;
                        end
                    end
                    default: st[c] <= IDLE;
                endcase
            end
        end
    end

    // Holding registers: a grant frees the slot on the same edge it may be refilled
    always_ff @(posedge lclk_i or posedge lrst_i) begin
        if (lrst_i) begin
            hold_valid <= '0;
            for (int c = 0; c < NCH; c++) hold_data[c] <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (accept[c] && (!hold_valid[c] || grant_oh[c])) begin
                    hold_valid[c] <= 1'b1;
                    hold_data[c]  <= {gc_lat[c], CW'(c), word[c]};
                end else if (grant_oh[c]) begin
                    hold_valid[c] <= 1'b0;
                end
            end
        end
    end

    // Round-robin search starting at rr_ptr, blocked while the FIFO is full
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        grant_oh  = '0;
        cand      = '0;
        if (!fifo_full) begin
            for (int i = 0; i < NCH; i++) begin
                cand = CW'((int'(rr_ptr) + i) % NCH);
                if (!grant_vld && hold_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant_ch  = cand;
                end
            end
        end
        if (grant_vld) grant_oh[grant_ch] = 1'b1;
    end

    // Arbiter pointer: next search starts after the last granted channel
    always_ff @(posedge lclk_i or posedge lrst_i) begin
        if (lrst_i)         rr_ptr <= '0;
        else if (grant_vld) rr_ptr <= (int'(grant_ch) == NCH - 1) ? '0 : grant_ch + CW'(1);
    end

    assign fifo_rd   = out_valid && m_axis_tready;
    assign fetch     = (mem_cnt != '0) && (!out_valid || fifo_rd);
    assign level     = mem_cnt + LW'(out_valid);
    assign fifo_full = (level == LW'(FIFO_DEPTH));

    // FIFO storage, written by the arbiter grant
    always_ff @(posedge lclk_i) begin
        if (grant_vld) mem[wr_ptr] <= hold_data[grant_ch];
    end

    // FIFO pointers and the registered fall-through output stage
    always_ff @(posedge lclk_i or posedge lrst_i) begin
        if (lrst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (grant_vld) wr_ptr <= wr_ptr + AW'(1);
            if (fetch) begin
                out_data <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
            end
            if (fetch)        out_valid <= 1'b1;
            else if (fifo_rd) out_valid <= 1'b0;
            case ({grant_vld, fetch})
                2'b10:   mem_cnt <= mem_cnt + LW'(1);
                2'b01:   mem_cnt <= mem_cnt - LW'(1);
                default: mem_cnt <= mem_cnt;
            endcase
        end
    end

    // Saturating drop and frame-error counters
    always_ff @(posedge lclk_i or posedge lrst_i) begin
        if (lrst_i) begin
            drop_cnt_o      <= '0;
            frame_err_cnt_o <= '0;
        end else begin
            drop_cnt_o      <= sat_add(drop_cnt_o, drop_n);
            frame_err_cnt_o <= sat_add(frame_err_cnt_o, err_n);
        end
    end

    assign m_axis_tdata  = out_data;
    assign m_axis_tvalid = out_valid;
    assign gc_o          = gc;
    assign fifo_level_o  = level;

endmodule

// File: tb/tb_as6501_rx_multi.sv
// Directed testbench for as6501_rx_multi with default parameters (NCH=4).
module tb_as6501_rx_multi;
    localparam int NCH = 4, IDX_W = 8, STOP_W = 16, GC_W = 48, FIFO_DEPTH = 16;
    localparam int CW = 2, RES_W = 24, DW = GC_W + CW + RES_W;

    logic              lclk_i = 1'b0;
    logic              lrst_i, enable_i, gc_rst_i, m_axis_tready, m_axis_tvalid;
    logic [NCH-1:0]    frame_i, sdi_i;
    logic [STOP_W-1:0] gate_lo_i, gate_hi_i;
    logic [DW-1:0]     m_axis_tdata;
    logic [GC_W-1:0]   gc_o;
    logic [15:0]       drop_cnt_o, frame_err_cnt_o;
    logic [4:0]        fifo_level_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [GC_W-1:0]  gc_model;
    logic [GC_W-1:0]  start_gc;
    logic [RES_W-1:0] tx_word [NCH];
    logic [DW-1:0]    rx_data [64];
    int               rx_n;

    as6501_rx_multi #(
        .NCH(NCH), .IDX_W(IDX_W), .STOP_W(STOP_W), .GC_W(GC_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .lclk_i(lclk_i), .lrst_i(lrst_i), .enable_i(enable_i), .gc_rst_i(gc_rst_i),
        .frame_i(frame_i), .sdi_i(sdi_i), .gate_lo_i(gate_lo_i), .gate_hi_i(gate_hi_i),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .gc_o(gc_o), .drop_cnt_o(drop_cnt_o), .frame_err_cnt_o(frame_err_cnt_o),
        .fifo_level_o(fifo_level_o)
    );

    always #5 lclk_i = ~lclk_i;

    // Reference global counter, used for frame-start tags
    always @(posedge lclk_i or posedge lrst_i) begin
        if (lrst_i)        gc_model <= '0;
        else if (gc_rst_i) gc_model <= '0;
        else if (enable_i) gc_model <= gc_model + 1;
    end

    task automatic do_reset;
        @(negedge lclk_i);
        lrst_i = 1'b1; frame_i = '0; sdi_i = '0; gc_rst_i = 1'b0;
        @(negedge lclk_i);
        @(negedge lclk_i);
        lrst_i = 1'b0;
    endtask

    // Drive the top nbits of tx_word on the masked channels, MSB first
    task automatic send(input logic [NCH-1:0] mask, input int nbits);
        for (int b = RES_W - 1; b >= RES_W - nbits; b--) begin
            @(negedge lclk_i);
            if (b == RES_W - 1) start_gc = gc_model;
            for (int c = 0; c < NCH; c++) begin
                frame_i[c] = mask[c] && (b == RES_W - 1);
                sdi_i[c]   = mask[c] ? tx_word[c][b] : 1'b0;
            end
        end
    endtask

    task automatic collect(input int cycles);
        rx_n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (m_axis_tvalid && m_axis_tready && rx_n < 64) begin
                rx_data[rx_n] = m_axis_tdata;
                rx_n++;
            end
            @(negedge lclk_i);
        end
    endtask

    task automatic test_reset;
        @(negedge lclk_i);
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
        n_checks++;
        if (m_axis_tdata !== '0) begin n_fail++; $display("FAIL reset_tdata: got %h expected 0", m_axis_tdata); end
        n_checks++;
        if (gc_o !== '0) begin n_fail++; $display("FAIL reset_gc: got %0d expected 0", gc_o); end
        n_checks++;
        if (drop_cnt_o !== 16'd0 || frame_err_cnt_o !== 16'd0) begin
            n_fail++; $display("FAIL reset_counters: got drop %0d err %0d expected 0 0", drop_cnt_o, frame_err_cnt_o);
        end
        n_checks++;
        if (fifo_level_o !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level_o); end
        lrst_i = 1'b0;
    endtask

    task automatic test_single_word;
        logic [DW-1:0] exp;
        do_reset;
        m_axis_tready = 1'b1;
        repeat (99) @(negedge lclk_i);
        tx_word[1] = 24'h0A1234;
        send(4'b0010, RES_W);
        exp = {48'd100, 2'd1, 8'h0A, 16'h1234};
        @(negedge lclk_i);
        @(negedge lclk_i);
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_latency: tvalid %b one cycle early, expected 0", m_axis_tvalid); end
        @(negedge lclk_i);
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp) begin
            n_fail++; $display("FAIL single_beat: got v=%b %h expected v=1 %h", m_axis_tvalid, m_axis_tdata, exp);
        end
        n_checks++;
        if (drop_cnt_o !== 16'd0 || frame_err_cnt_o !== 16'd0) begin
            n_fail++; $display("FAIL single_counters: got drop %0d err %0d expected 0 0", drop_cnt_o, frame_err_cnt_o);
        end
        @(negedge lclk_i);
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_once: got tvalid %b expected 0", m_axis_tvalid); end
    endtask

    task automatic test_round_robin;
        logic [DW-1:0] exp;
        int ch;
        do_reset;
        m_axis_tready = 1'b1;
        for (int c = 0; c < NCH; c++) tx_word[c] = {8'h10 + 8'(c), 16'hC000 + 16'(c)};
        send(4'hF, RES_W);
        @(negedge lclk_i);
        @(negedge lclk_i);
        for (int i = 0; i < NCH; i++) begin
            @(negedge lclk_i);
            exp = {start_gc, 2'(i), tx_word[i]};
            n_checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp) begin
                n_fail++; $display("FAIL rr_first_beat%0d: got v=%b %h expected v=1 %h", i, m_axis_tvalid, m_axis_tdata, exp);
            end
        end
        repeat (2) @(negedge lclk_i);
        send(4'b0100, RES_W);
        repeat (3) @(negedge lclk_i);
        exp = {start_gc, 2'd2, tx_word[2]};
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp) begin
            n_fail++; $display("FAIL rr_ch2_beat: got v=%b %h expected v=1 %h", m_axis_tvalid, m_axis_tdata, exp);
        end
        repeat (2) @(negedge lclk_i);
        send(4'hF, RES_W);
        @(negedge lclk_i);
        @(negedge lclk_i);
        for (int i = 0; i < NCH; i++) begin
            @(negedge lclk_i);
            ch  = (i + 3) % NCH;
            exp = {start_gc, 2'(ch), tx_word[ch]};
            n_checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp) begin
                n_fail++; $display("FAIL rr_second_beat%0d: got v=%b %h expected v=1 %h", i, m_axis_tvalid, m_axis_tdata, exp);
            end
        end
    endtask

    task automatic test_reframe;
        logic [DW-1:0] exp;
        do_reset;
        m_axis_tready = 1'b1;
        tx_word[0] = 24'hFFFFFF;
        send(4'b0001, 10);
        tx_word[0] = 24'h5A0042;
        send(4'b0001, RES_W);
        exp = {start_gc, 2'd0, 8'h5A, 16'h0042};
        repeat (3) @(negedge lclk_i);
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp) begin
            n_fail++; $display("FAIL reframe_beat: got v=%b %h expected v=1 %h", m_axis_tvalid, m_axis_tdata, exp);
        end
        @(negedge lclk_i);
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reframe_single: got tvalid %b expected 0", m_axis_tvalid); end
        n_checks++;
        if (frame_err_cnt_o !== 16'd1) begin n_fail++; $display("FAIL reframe_errcnt: got %0d expected 1", frame_err_cnt_o); end
    endtask

    task automatic test_backpressure;
        logic [GC_W-1:0] gcs [18];
        logic [DW-1:0]   exp;
        do_reset;
        m_axis_tready = 1'b0;
        for (int k = 0; k < 18; k++) begin
            tx_word[0] = {8'(k), 16'h0100 + 16'(k)};
            send(4'b0001, RES_W);
            gcs[k] = start_gc;
        end
        repeat (3) @(negedge lclk_i);
        n_checks++;
        if (fifo_level_o !== 5'd16) begin n_fail++; $display("FAIL bp_level: got %0d expected 16", fifo_level_o); end
        n_checks++;
        if (drop_cnt_o !== 16'd1) begin n_fail++; $display("FAIL bp_drop: got %0d expected 1", drop_cnt_o); end
        exp = {gcs[0], 2'd0, 8'd0, 16'h0100};
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp) begin
            n_fail++; $display("FAIL bp_stable: got v=%b %h expected v=1 %h", m_axis_tvalid, m_axis_tdata, exp);
        end
        m_axis_tready = 1'b1;
        collect(40);
        n_checks++;
        if (rx_n !== 17) begin n_fail++; $display("FAIL bp_count: got %0d beats expected 17", rx_n); end
        for (int k = 0; k < 17 && k < rx_n; k++) begin
            exp = {gcs[k], 2'd0, 8'(k), 16'h0100 + 16'(k)};
            n_checks++;
            if (rx_data[k] !== exp) begin n_fail++; $display("FAIL bp_beat%0d: got %h expected %h", k, rx_data[k], exp); end
        end
    endtask

    task automatic test_gate_filter;
        logic [STOP_W-1:0] stops [4];
        stops[0] = 16'h00FF; stops[1] = 16'h0100; stops[2] = 16'h0200; stops[3] = 16'h0201;
        do_reset;
        m_axis_tready = 1'b0;
        gate_lo_i = 16'h0100;
        gate_hi_i = 16'h0200;
        for (int k = 0; k < 4; k++) begin
            tx_word[3] = {8'h33, stops[k]};
            send(4'b1000, RES_W);
        end
        repeat (3) @(negedge lclk_i);
        m_axis_tready = 1'b1;
        collect(20);
`ifdef AS6501_GATE_FILTER_EN
        n_checks++;
        if (rx_n !== 2) begin n_fail++; $display("FAIL gate_count: got %0d beats expected 2", rx_n); end
        n_checks++;
        if (rx_data[0][STOP_W-1:0] !== 16'h0100 || rx_data[1][STOP_W-1:0] !== 16'h0200) begin
            n_fail++; $display("FAIL gate_stops: got %h %h expected 0100 0200", rx_data[0][STOP_W-1:0], rx_data[1][STOP_W-1:0]);
        end
        n_checks++;
        if (drop_cnt_o !== 16'd0) begin n_fail++; $display("FAIL gate_drop: got %0d expected 0", drop_cnt_o); end
`else
        n_checks++;
        if (rx_n !== 4) begin n_fail++; $display("FAIL nogate_count: got %0d beats expected 4", rx_n); end
        n_checks++;
        if (rx_data[0][STOP_W-1:0] !== 16'h00FF || rx_data[3][STOP_W-1:0] !== 16'h0201) begin
            n_fail++; $display("FAIL nogate_stops: got %h %h expected 00ff 0201", rx_data[0][STOP_W-1:0], rx_data[3][STOP_W-1:0]);
        end
`endif
        n_checks++;
        if (rx_data[0][RES_W +: CW] !== 2'd3) begin n_fail++; $display("FAIL gate_channel: got %0d expected 3", rx_data[0][RES_W +: CW]); end
    endtask

    task automatic test_reset_mid_and_gc_rst;
        do_reset;
        m_axis_tready = 1'b0;
        tx_word[0] = 24'h112233;
        send(4'b0001, RES_W);
        tx_word[2] = 24'hABCDEF;
        send(4'b0100, 5);
        send(4'b0100, 5);
        n_checks++;
        if (frame_err_cnt_o !== 16'd1 || m_axis_tvalid !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre: got err %0d tvalid %b expected 1 1", frame_err_cnt_o, m_axis_tvalid);
        end
        #2 lrst_i = 1'b1;
        #1;
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || fifo_level_o !== 5'd0 || gc_o !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs: got v=%b d=%h lvl=%0d gc=%0d expected 0 0 0 0", m_axis_tvalid, m_axis_tdata, fifo_level_o, gc_o);
        end
        n_checks++;
        if (frame_err_cnt_o !== 16'd0 || drop_cnt_o !== 16'd0) begin
            n_fail++; $display("FAIL rstmid_counters: got err %0d drop %0d expected 0 0", frame_err_cnt_o, drop_cnt_o);
        end
        frame_i = '0;
        @(negedge lclk_i);
        @(negedge lclk_i);
        lrst_i = 1'b0;
        repeat (5) @(negedge lclk_i);
        n_checks++;
        if (gc_o !== 48'd5) begin n_fail++; $display("FAIL gc_count: got %0d expected 5", gc_o); end
        gc_rst_i = 1'b1;
        @(negedge lclk_i);
        gc_rst_i = 1'b0;
        n_checks++;
        if (gc_o !== 48'd0) begin n_fail++; $display("FAIL gc_clear: got %0d expected 0", gc_o); end
        @(negedge lclk_i);
        n_checks++;
        if (gc_o !== 48'd1) begin n_fail++; $display("FAIL gc_resume: got %0d expected 1", gc_o); end
        m_axis_tready = 1'b1;
        collect(40);
        n_checks++;
        if (rx_n !== 0) begin n_fail++; $display("FAIL rstmid_lost: got %0d beats expected 0", rx_n); end
        n_checks++;
        if (frame_err_cnt_o !== 16'd0) begin n_fail++; $display("FAIL rstmid_errcnt: got %0d expected 0", frame_err_cnt_o); end
    endtask

    initial begin
        lrst_i        = 1'b1;
        enable_i      = 1'b1;
        gc_rst_i      = 1'b0;
        frame_i       = '0;
        sdi_i         = '0;
        gate_lo_i     = 16'h0100;
        gate_hi_i     = 16'h0200;
        m_axis_tready = 1'b1;
        for (int c = 0; c < NCH; c++) tx_word[c] = '0;
        test_reset;
        test_single_word;
        test_round_robin;
        test_reframe;
        test_backpressure;
        test_gate_filter;
        test_reset_mid_and_gc_rst;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
